// File: rtl/riscv_alu.sv
// RV32I integer ALU: add/sub, shifts, compares, logic ops on a 4-bit select.
// Define ALU_OUT_REG_EN to register ALU_OUT and flags (1-cycle latency).
module riscv_alu #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] BUS_A,
  input  logic [WIDTH-1:0] BUS_B,
  input  logic [3:0]       ALUSel,
  output logic [WIDTH-1:0] ALU_OUT,
  output logic             ZERO_FLAG,
  output logic             NEG_FLAG
);

  localparam int S = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SLT  = 4'd3,
    OP_SLTU = 4'd4,
    OP_XOR  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_OR   = 4'd8,
    OP_AND  = 4'd9
  } alu_op_e;

  logic [S-1:0]     shamt;
  logic             lt_s;
  logic             lt_u;
  logic [WIDTH-1:0] res;
  logic             res_zero;
  logic             res_neg;

  assign shamt = BUS_B[S-1:0];
  assign lt_s  = $signed(BUS_A) < $signed(BUS_B);
  assign lt_u  = BUS_A < BUS_B;

  always_comb begin
    res = '0;
    case (ALUSel)
      OP_ADD:  res = BUS_A + BUS_B;
      OP_SUB:  res = BUS_A - BUS_B;
      OP_SLL:  res = BUS_A << shamt;
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, lt_s};
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, lt_u};
      OP_XOR:  res = BUS_A ^ BUS_B;
      OP_SRL:  res = BUS_A >> shamt;
      OP_SRA:  res = WIDTH'($signed(BUS_A) >>> shamt);
      OP_OR:   res = BUS_A | BUS_B;
      OP_AND:  res = BUS_A & BUS_B;
      default: res = '0;
    endcase
  end

  assign res_zero = (res == '0);
  assign res_neg  = res[WIDTH-1];

`ifdef ALU_OUT_REG_EN
  logic [WIDTH-1:0] out_d, out_q;
  logic             zero_d, zero_q;
  logic             neg_d, neg_q;

  always_comb begin
    out_d  = res;
    zero_d = res_zero;
    neg_d  = res_neg;
  end

  // Reset value keeps flags consistent with a zero result
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_q  <= '0;
      zero_q <= 1'b1;
      neg_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      zero_q <= zero_d;
      neg_q  <= neg_d;
    end
  end

  assign ALU_OUT   = out_q;
  assign ZERO_FLAG = zero_q;
  assign NEG_FLAG  = neg_q;
`else
  logic unused_clk_rst;
  assign unused_clk_rst = CLK ^ RST_N;

  assign ALU_OUT   = res;
  assign ZERO_FLAG = res_zero;
  assign NEG_FLAG  = res_neg;
`endif

endmodule

// File: tb/tb_riscv_alu.sv
// Directed-vector bench for riscv_alu, combinational or registered build.
module tb_riscv_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  sel;
  logic [31:0] alu_out;
  logic        zero_flag;
  logic        neg_flag;

  int checks;
  int errors;

  riscv_alu #(.WIDTH(32)) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .BUS_A     (a),
    .BUS_B     (b),
    .ALUSel    (sel),
    .ALU_OUT   (alu_out),
    .ZERO_FLAG (zero_flag),
    .NEG_FLAG  (neg_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] eo,
                       input logic ez, input logic en);
    checks++;
    assert ({alu_out, zero_flag, neg_flag} === {eo, ez, en}) else begin
      errors++;
      $display("FAIL %s: got out=%h z=%b n=%b, want out=%h z=%b n=%b",
               tag, alu_out, zero_flag, neg_flag, eo, ez, en);
      $error("%s mismatch", tag);
    end
  endtask

  task automatic apply(input logic [31:0] ta, input logic [31:0] tb,
                       input logic [3:0] ts);
    a   = ta;
    b   = tb;
    sel = ts;
`ifdef ALU_OUT_REG_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    a = 32'd0;
    b = 32'd0;
    sel = 4'd0;
    rst_n = 1'b0;
    #12;
`ifdef ALU_OUT_REG_EN
    a = 32'd4; b = 32'd2; sel = 4'd8;
    @(posedge clk); #1;
    check("reset_hold", 32'd0, 1'b1, 1'b0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

`ifdef ALU_OUT_REG_EN
    a = 32'd4; b = 32'd2; sel = 4'd8;
    @(posedge clk); #1;
    check("reg_first_edge", 32'd6, 1'b0, 1'b0);
`endif

    apply(32'd4, 32'd2, 4'd7);  check("sra_4_2", 32'd1, 1'b0, 1'b0);
    apply(32'd4, 32'd2, 4'd8);  check("or_4_2",  32'd6, 1'b0, 1'b0);
    apply(32'd4, 32'd2, 4'd9);  check("and_4_2", 32'd0, 1'b1, 1'b0);
    apply(32'd4, 32'd2, 4'd0);  check("add_4_2", 32'd6, 1'b0, 1'b0);
    apply(32'd4, 32'd2, 4'd1);  check("sub_4_2", 32'd2, 1'b0, 1'b0);
    apply(32'd4, 32'd2, 4'd2);  check("sll_4_2", 32'd16, 1'b0, 1'b0);
    apply(32'd4, 32'd2, 4'd5);  check("xor_4_2", 32'd6, 1'b0, 1'b0);
    apply(32'd4, 32'd2, 4'd6);  check("srl_4_2", 32'd1, 1'b0, 1'b0);

    apply(32'h8000_0000, 32'd0, 4'd3);
    check("slt_min_0", 32'd1, 1'b0, 1'b0);
    apply(32'h8000_0000, 32'd0, 4'd4);
    check("sltu_min_0", 32'd0, 1'b1, 1'b0);
    apply(32'h8000_0000, 32'd4, 4'd7);
    check("sra_min_4", 32'hF800_0000, 1'b0, 1'b1);
    apply(32'h8000_0000, 32'd4, 4'd6);
    check("srl_min_4", 32'h0800_0000, 1'b0, 1'b0);
    apply(32'h7FFF_FFFF, 32'd1, 4'd0);
    check("add_wrap", 32'h8000_0000, 1'b0, 1'b1);
    apply(32'hFFFF_FFFF, 32'd1, 4'd0);
    check("add_carry", 32'd0, 1'b1, 1'b0);
    apply(32'd0, 32'd1, 4'd1);
    check("sub_wrap", 32'hFFFF_FFFF, 1'b0, 1'b1);
    apply(32'd1, 32'd33, 4'd2);
    check("sll_b33", 32'd2, 1'b0, 1'b0);
    apply(32'hF000_0000, 32'd36, 4'd6);
    check("srl_b36", 32'h0F00_0000, 1'b0, 1'b0);
    apply(32'h8765_4321, 32'd32, 4'd7);
    check("sra_b32", 32'h8765_4321, 1'b0, 1'b1);
    apply(32'h8765_4321, 32'd0, 4'd2);
    check("sll_0", 32'h8765_4321, 1'b0, 1'b1);
    apply(32'hFFFF_FFF6, 32'hFFFF_FFF6, 4'd3);
    check("slt_eq", 32'd0, 1'b1, 1'b0);
    apply(32'hFFFF_FFF6, 32'hFFFF_FFF6, 4'd4);
    check("sltu_eq", 32'd0, 1'b1, 1'b0);
    apply(32'hFFFF_FFFF, 32'd1, 4'd3);
    check("slt_neg1_1", 32'd1, 1'b0, 1'b0);
    apply(32'hFFFF_FFFF, 32'd1, 4'd4);
    check("sltu_max_1", 32'd0, 1'b1, 1'b0);
    apply(32'd5, 32'hFFFF_FFFF, 4'd4);
    check("sltu_5_max", 32'd1, 1'b0, 1'b0);
    apply(32'hF0F0_1234, 32'h0FF0_FF00, 4'd5);
    check("xor_pat", 32'hFF00_ED34, 1'b0, 1'b1);
    apply(32'hF0F0_1234, 32'h0FF0_FF00, 4'd8);
    check("or_pat", 32'hFFF0_FF34, 1'b0, 1'b1);
    apply(32'hF0F0_1234, 32'h0FF0_FF00, 4'd9);
    check("and_pat", 32'h00F0_1200, 1'b0, 1'b0);

    for (int s = 10; s < 16; s++) begin
      apply(32'hDEAD_BEEF, 32'h1234_5678, 4'(s));
      check($sformatf("reserved_%0d", s), 32'd0, 1'b1, 1'b0);
    end

`ifdef ALU_OUT_REG_EN
    apply(32'h7FFF_FFFF, 32'd1, 4'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear", 32'd0, 1'b1, 1'b0);
    rst_n = 1'b1;
`else
    a = 32'h7FFF_FFFF; b = 32'd1; sel = 4'd0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_no_effect", 32'h8000_0000, 1'b0, 1'b1);
    @(posedge clk); #1;
    check("clk_no_effect", 32'h8000_0000, 1'b0, 1'b1);
    rst_n = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
